// File: rtl/rca_att_config_seq.sv
// ATT configuration sequencer for the RCA profiler.
// Installs triggers into the Accelerator Trigger Table. The slot choice is, in
// order: an existing entry with the same loop start, the lowest free slot, or
// the round-robin victim. The sequencer also flushes the whole table on request.
// Field writes go out one at a time over a valid/ack port.
// An entry is invalidated before its fields are rewritten, and its VALID bit is
// set last, so fetch never sees a valid half-written entry.
// A shadow copy of the valid bits and loop start addresses serves lookups
// without reading the ATT.
//
// Handshakes:
//   req:    a transfer happens on a rising edge where req_valid && req_ready.
//   att_wr: att_wr_valid rises with rca_addr/field_id/value and holds all of them
//           stable until the edge where att_wr_ack=1, which retires the write.
//           At most one write is outstanding. An ack while att_wr_valid=0 has
//           no effect.
module rca_att_config_seq #(
  parameter int NUM_RCAS = 4,
  parameter int XLEN     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [XLEN-1:0]             req_loop_start,
  input  logic [XLEN-1:0]             req_sbb_addr,
  input  logic                        flush,
  output logic                        att_wr_valid,
  input  logic                        att_wr_ack,
  output logic [$clog2(NUM_RCAS)-1:0] att_wr_rca_addr,
  output logic [1:0]                  att_wr_field_id,
  output logic [XLEN-1:0]             att_wr_value,
  output logic                        done_valid,
  output logic [$clog2(NUM_RCAS)-1:0] done_rca,
  output logic                        done_hit,
  output logic                        busy,
  output logic [2:0]                  state_dbg
);

  localparam int IW = $clog2(NUM_RCAS);

  localparam logic [1:0] FIELD_SBB   = 2'd0;
  localparam logic [1:0] FIELD_LSA   = 2'd1;
  localparam logic [1:0] FIELD_VALID = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WR_INVAL,
    S_WR_SBB,
    S_WR_LSA,
    S_WR_VALID,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t                state;
  logic                  flush_pending;
  logic [IW-1:0]         victim_ptr;
  logic [IW-1:0]         slot;          // install target, or flush slot counter
  logic [XLEN-1:0]       req_lsa_q;
  logic [XLEN-1:0]       req_sbb_q;
  logic [NUM_RCAS-1:0]   shadow_valid;
  logic [XLEN-1:0]       shadow_lsa [NUM_RCAS];

  logic                  hit_found;
  logic [IW-1:0]         hit_idx;
  logic                  free_found;
  logic [IW-1:0]         free_idx;

  // Requests are held off during reset and whenever a flush is owed or arriving.
  assign req_ready = !rst && (state == S_IDLE) && !flush_pending && !flush;
  assign busy      = (state != S_IDLE) || flush_pending;
  assign state_dbg = state;

  // Shadow lookup: the downward scan leaves the lowest matching and lowest free index.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_RCAS - 1; i >= 0; i--) begin
      if (shadow_valid[i] && (shadow_lsa[i] == req_lsa_q)) begin
        hit_found = 1'b1;
        hit_idx   = IW'(i);
      end
      if (!shadow_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Sequencer FSM with registered write-port and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      flush_pending   <= 1'b0;
      victim_ptr      <= '0;
      slot            <= '0;
      req_lsa_q       <= '0;
      req_sbb_q       <= '0;
      shadow_valid    <= '0;
      for (int i = 0; i < NUM_RCAS; i++) shadow_lsa[i] <= '0;
      att_wr_valid    <= 1'b0;
      att_wr_rca_addr <= '0;
      att_wr_field_id <= '0;
      att_wr_value    <= '0;
      done_valid      <= 1'b0;
      done_rca        <= '0;
      done_hit        <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_pending) begin
            flush_pending   <= 1'b0;
            slot            <= '0;
            att_wr_valid    <= 1'b1;
            att_wr_rca_addr <= '0;
            att_wr_field_id <= FIELD_VALID;
            att_wr_value    <= '0;
            state           <= S_FLUSH;
          end else if (req_valid && req_ready) begin
            req_lsa_q <= req_loop_start;
            req_sbb_q <= req_sbb_addr;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_found) begin
            done_valid <= 1'b1;
            done_rca   <= hit_idx;
            done_hit   <= 1'b1;
            state      <= S_DONE;
          end else if (free_found) begin
            slot            <= free_idx;
            att_wr_valid    <= 1'b1;
            att_wr_rca_addr <= free_idx;
            att_wr_field_id <= FIELD_SBB;
            att_wr_value    <= req_sbb_q;
            state           <= S_WR_SBB;
          end else begin
            slot            <= victim_ptr;
            victim_ptr      <= victim_ptr + 1'b1;
            att_wr_valid    <= 1'b1;
            att_wr_rca_addr <= victim_ptr;
            att_wr_field_id <= FIELD_VALID;
            att_wr_value    <= '0;
            state           <= S_WR_INVAL;
          end
        end
        S_WR_INVAL: begin
          if (att_wr_ack) begin
            shadow_valid[slot] <= 1'b0;
            att_wr_field_id    <= FIELD_SBB;
            att_wr_value       <= req_sbb_q;
            state              <= S_WR_SBB;
          end
        end
        S_WR_SBB: begin
          if (att_wr_ack) begin
            att_wr_field_id <= FIELD_LSA;
            att_wr_value    <= req_lsa_q;
            state           <= S_WR_LSA;
          end
        end
        S_WR_LSA: begin
          if (att_wr_ack) begin
            att_wr_field_id <= FIELD_VALID;
            att_wr_value    <= XLEN'(1);
            state           <= S_WR_VALID;
          end
        end
        S_WR_VALID: begin
          if (att_wr_ack) begin
            shadow_valid[slot] <= 1'b1;
            shadow_lsa[slot]   <= req_lsa_q;
            att_wr_valid       <= 1'b0;
            done_valid         <= 1'b1;
            done_rca           <= slot;
            done_hit           <= 1'b0;
            state              <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_FLUSH: begin
          if (att_wr_ack) begin
            shadow_valid[slot] <= 1'b0;
            if (slot == IW'(NUM_RCAS - 1)) begin
              att_wr_valid <= 1'b0;
              victim_ptr   <= '0;
              state        <= S_IDLE;
            end else begin
              slot            <= slot + 1'b1;
              att_wr_rca_addr <= slot + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // A flush pulse in any state leaves a flush owed, including during FLUSH itself.
      if (flush) flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rca_att_config_seq.sv
// Directed bench for rca_att_config_seq: install, hit, eviction, delayed ack,
// flush during install and reset during a write.
module tb_rca_att_config_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_loop_start;
  logic [31:0] req_sbb_addr;
  logic        flush;
  logic        att_wr_valid;
  logic        att_wr_ack;
  logic [1:0]  att_wr_rca_addr;
  logic [1:0]  att_wr_field_id;
  logic [31:0] att_wr_value;
  logic        done_valid;
  logic [1:0]  done_rca;
  logic        done_hit;
  logic        busy;
  logic [2:0]  state_dbg;

  int tests;
  int fails;

  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int          stab_err;

  rca_att_config_seq #(.NUM_RCAS(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_loop_start(req_loop_start), .req_sbb_addr(req_sbb_addr),
    .flush(flush),
    .att_wr_valid(att_wr_valid), .att_wr_ack(att_wr_ack),
    .att_wr_rca_addr(att_wr_rca_addr), .att_wr_field_id(att_wr_field_id),
    .att_wr_value(att_wr_value),
    .done_valid(done_valid), .done_rca(done_rca), .done_hit(done_hit),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [35:0] wr(input logic [1:0] a, input logic [1:0] f,
                                     input logic [31:0] v);
    return {a, f, v};
  endfunction

  // Driver: issue one install and service the write port with a fixed ack delay.
  // Called and returning on a negedge; done_cyc counts from the accept cycle (0).
  task automatic run_install(input logic [31:0] lsa, input logic [31:0] sbb,
                             input int delay, output int done_cyc,
                             output logic [1:0] rca, output logic hit);
    int          waited;
    int          wait_rdy;
    logic        pend;
    logic [35:0] held;
    got_q.delete();
    stab_err = 0;
    done_cyc = -1;
    rca      = 2'd0;
    hit      = 1'b0;
    waited   = 0;
    pend     = 1'b0;
    held     = '0;
    req_valid      = 1'b1;
    req_loop_start = lsa;
    req_sbb_addr   = sbb;
    wait_rdy = 0;
    while (!req_ready && wait_rdy < 50) begin
      @(negedge clk);
      wait_rdy++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c < 60; c++) begin
      if (done_valid) begin
        done_cyc = c;
        rca      = done_rca;
        hit      = done_hit;
        break;
      end
      if (att_wr_valid) begin
        if (pend && ({att_wr_rca_addr, att_wr_field_id, att_wr_value} !== held))
          stab_err++;
        held = {att_wr_rca_addr, att_wr_field_id, att_wr_value};
        if (waited >= delay) begin
          att_wr_ack = 1'b1;
          got_q.push_back(held);
          waited = 0;
          pend   = 1'b0;
        end else begin
          att_wr_ack = 1'b0;
          waited++;
          pend = 1'b1;
        end
      end else begin
        att_wr_ack = 1'b0;
        pend       = 1'b0;
      end
      @(negedge clk);
    end
    att_wr_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_in_rst: got %b expected 0", req_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (att_wr_valid !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: wr_valid=%b done_valid=%b busy=%b expected 0 0 0",
               att_wr_valid, done_valid, busy);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_free_install();
    int cyc; logic [1:0] rca; logic hit;
    run_install(32'h100, 32'h180, 0, cyc, rca, hit);
    exp_q.delete();
    exp_q.push_back(wr(2'd0, 2'd0, 32'h180));
    exp_q.push_back(wr(2'd0, 2'd1, 32'h100));
    exp_q.push_back(wr(2'd0, 2'd2, 32'h1));
    tests++;
    if (cyc != 5 || rca !== 2'd0 || hit !== 1'b0) begin
      fails++; $display("FAIL free_done: cyc=%0d rca=%0d hit=%b expected 5 0 0", cyc, rca, hit);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL free_wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL free_wr[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_hit();
    int cyc; logic [1:0] rca; logic hit;
    run_install(32'h100, 32'h999, 0, cyc, rca, hit);
    tests++;
    if (cyc != 2 || rca !== 2'd0 || hit !== 1'b1) begin
      fails++; $display("FAIL hit_done: cyc=%0d rca=%0d hit=%b expected 2 0 1", cyc, rca, hit);
    end
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL hit_no_writes: got %0d writes expected 0", got_q.size());
    end
  endtask

  task automatic test_evict();
    int cyc; logic [1:0] rca; logic hit;
    for (int s = 1; s < 4; s++) begin
      run_install(32'h100 * (s + 1), 32'h100 * (s + 1) + 32'h80, 0, cyc, rca, hit);
      tests++;
      if (cyc != 5 || rca !== 2'(s) || hit !== 1'b0) begin
        fails++;
        $display("FAIL fill_slot%0d: cyc=%0d rca=%0d hit=%b expected 5 %0d 0", s, cyc, rca, hit, s);
      end
    end
    run_install(32'h500, 32'h580, 0, cyc, rca, hit);
    exp_q.delete();
    exp_q.push_back(wr(2'd0, 2'd2, 32'h0));
    exp_q.push_back(wr(2'd0, 2'd0, 32'h580));
    exp_q.push_back(wr(2'd0, 2'd1, 32'h500));
    exp_q.push_back(wr(2'd0, 2'd2, 32'h1));
    tests++;
    if (cyc != 6 || rca !== 2'd0 || hit !== 1'b0) begin
      fails++; $display("FAIL evict0_done: cyc=%0d rca=%0d hit=%b expected 6 0 0", cyc, rca, hit);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL evict0_wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL evict0_wr[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    run_install(32'h600, 32'h680, 0, cyc, rca, hit);
    tests++;
    if (cyc != 6 || rca !== 2'd1 || got_q.size() != 4) begin
      fails++; $display("FAIL evict1_done: cyc=%0d rca=%0d writes=%0d expected 6 1 4", cyc, rca, got_q.size());
    end else begin
      tests++;
      if (got_q[0] !== wr(2'd1, 2'd2, 32'h0)) begin
        fails++; $display("FAIL evict1_first_wr: got %h expected %h", got_q[0], wr(2'd1, 2'd2, 32'h0));
      end
    end
  endtask

  task automatic test_delayed_ack();
    int cyc; logic [1:0] rca; logic hit;
    run_install(32'h700, 32'h780, 3, cyc, rca, hit);
    exp_q.delete();
    exp_q.push_back(wr(2'd2, 2'd2, 32'h0));
    exp_q.push_back(wr(2'd2, 2'd0, 32'h780));
    exp_q.push_back(wr(2'd2, 2'd1, 32'h700));
    exp_q.push_back(wr(2'd2, 2'd2, 32'h1));
    tests++;
    if (cyc != 18 || rca !== 2'd2 || hit !== 1'b0) begin
      fails++; $display("FAIL delay_done: cyc=%0d rca=%0d hit=%b expected 18 2 0", cyc, rca, hit);
    end
    tests++;
    if (stab_err != 0) begin
      fails++; $display("FAIL delay_stable: got %0d unstable cycles expected 0", stab_err);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL delay_wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL delay_wr[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int cyc; logic [1:0] rca; logic hit;
    int n_done; int rdy_err; int wait_rdy;
    logic flushed; logic ended; logic [1:0] d_rca; logic d_hit;
    got_q.delete();
    n_done = 0; rdy_err = 0; flushed = 1'b0; ended = 1'b0; d_rca = 2'd0; d_hit = 1'b0;
    req_valid = 1'b1; req_loop_start = 32'h800; req_sbb_addr = 32'h880;
    wait_rdy = 0;
    while (!req_ready && wait_rdy < 50) begin
      @(negedge clk);
      wait_rdy++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c < 80; c++) begin
      flush = 1'b0;
      if (done_valid) begin
        n_done++; d_rca = done_rca; d_hit = done_hit;
      end
      if (flushed && busy && req_ready) rdy_err++;
      if (flushed && n_done > 0 && !busy) begin
        ended = 1'b1;
        break;
      end
      if (att_wr_valid) begin
        att_wr_ack = 1'b1;
        got_q.push_back({att_wr_rca_addr, att_wr_field_id, att_wr_value});
        if (!flushed && att_wr_field_id == 2'd1) begin
          flush   = 1'b1;
          flushed = 1'b1;
        end
      end else begin
        att_wr_ack = 1'b0;
      end
      @(negedge clk);
    end
    att_wr_ack = 1'b0;
    flush      = 1'b0;
    exp_q.delete();
    exp_q.push_back(wr(2'd3, 2'd2, 32'h0));
    exp_q.push_back(wr(2'd3, 2'd0, 32'h880));
    exp_q.push_back(wr(2'd3, 2'd1, 32'h800));
    exp_q.push_back(wr(2'd3, 2'd2, 32'h1));
    for (int s = 0; s < 4; s++) exp_q.push_back(wr(2'(s), 2'd2, 32'h0));
    tests++;
    if (!ended) begin
      fails++; $display("FAIL flush_timeout: busy=%b done_count=%0d expected idle", busy, n_done);
    end
    tests++;
    if (n_done != 1 || d_rca !== 2'd3 || d_hit !== 1'b0) begin
      fails++; $display("FAIL flush_install_done: count=%0d rca=%0d hit=%b expected 1 3 0", n_done, d_rca, d_hit);
    end
    tests++;
    if (rdy_err != 0) begin
      fails++; $display("FAIL flush_ready_low: got %0d ready cycles expected 0", rdy_err);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL flush_wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL flush_wr[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    run_install(32'h100, 32'h180, 0, cyc, rca, hit);
    tests++;
    if (cyc != 5 || rca !== 2'd0 || hit !== 1'b0) begin
      fails++; $display("FAIL post_flush_install: cyc=%0d rca=%0d hit=%b expected 5 0 0", cyc, rca, hit);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [1:0] rca; logic hit; int n;
    req_valid = 1'b1; req_loop_start = 32'h900; req_sbb_addr = 32'h980;
    att_wr_ack = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(att_wr_valid && att_wr_field_id == 2'd0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!(att_wr_valid && att_wr_field_id == 2'd0 && att_wr_rca_addr == 2'd1)) begin
      fails++;
      $display("FAIL midrst_wr_sbb: valid=%b field=%0d slot=%0d expected 1 0 1",
               att_wr_valid, att_wr_field_id, att_wr_rca_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (att_wr_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_state: wr_valid=%b busy=%b ready=%b expected 0 0 1",
               att_wr_valid, busy, req_ready);
    end
    run_install(32'h100, 32'h1c0, 0, cyc, rca, hit);
    tests++;
    if (cyc != 5 || rca !== 2'd0 || hit !== 1'b0) begin
      fails++; $display("FAIL midrst_install: cyc=%0d rca=%0d hit=%b expected 5 0 0", cyc, rca, hit);
    end
    tests++;
    if (got_q.size() != 3 || got_q[0] !== wr(2'd0, 2'd0, 32'h1c0)) begin
      fails++; $display("FAIL midrst_first_wr: writes=%0d expected 3 starting %h", got_q.size(), wr(2'd0, 2'd0, 32'h1c0));
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req_valid = 1'b0; req_loop_start = '0; req_sbb_addr = '0;
    flush = 1'b0; att_wr_ack = 1'b0;
    tests = 0; fails = 0;
    @(negedge clk);
    test_reset();
    test_free_install();
    test_hit();
    test_evict();
    test_delayed_ack();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rca_att_config_seq.md
Name: rca_att_config_seq

Overview:
Sequencer that installs, replaces and flushes entries in the Accelerator Trigger Table (ATT) on behalf of the RCA profiler.
- Accepts "install trigger" requests (loop start address, SBB address) and picks a slot: duplicate, then free, then round-robin victim.
- Issues the ATT field writes one at a time over a valid/ack port, in an order that never exposes a valid, half-written entry to fetch.
- Keeps a shadow copy of the valid bits and loop start addresses, so lookups never read the ATT.

Parameters:
NUM_RCAS, 4, number of ATT slots / RCAs (power of 2, >=2)
XLEN, 32, address and field width

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  profiler install request
req_ready  out  1  request accepted when req_valid && req_ready
req_loop_start  in  XLEN  loop start address (trigger PC)
req_sbb_addr  in  XLEN  address execution resumes at after the RCA
flush  in  1  single-cycle pulse: invalidate all slots
att_wr_valid  out  1  ATT field write pending
att_wr_ack  in  1  ATT accepted the write
att_wr_rca_addr  out  $clog2(NUM_RCAS)  target slot
att_wr_field_id  out  2  0=SBB_ADDR, 1=LOOP_START_ADDR, 2=VALID
att_wr_value  out  XLEN  field value; VALID uses bit 0
done_valid  out  1  one-cycle pulse when an install completes
done_rca  out  $clog2(NUM_RCAS)  slot used; valid with done_valid
done_hit  out  1  request matched an existing valid entry; no writes were issued
busy  out  1  state != IDLE or flush pending

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset has priority over everything and may assert mid-operation.
  - On reset: state=IDLE; shadow valid bits=0; shadow addresses=0; victim_ptr=0; flush_pending=0; all outputs 0.
  - Any in-flight write is abandoned.
- flush: a pulse in any state sets flush_pending. flush_pending clears when the FLUSH sequence starts.
- req_ready = (state==IDLE) && !flush_pending && !flush.
- Request capture: on acceptance, latch loop_start and sbb_addr, then go to LOOKUP.
- IDLE: if flush_pending, go to FLUSH with slot counter=0. Else, on accept, go to LOOKUP.
- LOOKUP (1 cycle), first match wins:
  - Shadow entry valid with equal loop_start: go to DONE with hit=1, slot=matching index (lowest on multiple). No ATT writes.
  - Else any invalid slot: take the lowest-index invalid slot and go to WR_SBB.
  - Else evict slot victim_ptr: go to WR_INVAL, then victim_ptr = (victim_ptr+1) mod NUM_RCAS.
- Write states each drive att_wr_valid=1 with rca_addr, field_id and value held stable until the cycle att_wr_ack=1. Advance on that cycle.
  - WR_INVAL (VALID, 0) → WR_SBB. Shadow valid cleared on ack.
  - WR_SBB (SBB_ADDR, sbb) → WR_LSA.
  - WR_LSA (LOOP_START_ADDR, loop_start) → WR_VALID.
  - WR_VALID (VALID, 1) → DONE. Shadow valid and loop_start set on ack.
- Write port rules: at most one write outstanding. att_wr_valid never drops before ack. att_wr_ack while att_wr_valid=0 is ignored.
- DONE (1 cycle): done_valid=1 with done_rca and done_hit, then → IDLE.
- FLUSH: for slot counter 0..NUM_RCAS-1, write (VALID, 0) to each slot, every slot regardless of shadow state.
  - Clear that slot's shadow valid on its ack.
  - After the last ack → IDLE. victim_ptr is reset to 0.
  - No done pulse is generated.
- flush arriving during an install: the install completes normally, including DONE; FLUSH starts on the next IDLE cycle.
- A flush pulse during FLUSH re-arms flush_pending, so a second full flush sequence runs.
- Latency with ack returned combinationally the same cycle:
  - Hit: accept at cycle 0, LOOKUP at 1, done_valid at 2.
  - Free-slot install: done_valid at 5.
  - Eviction: done_valid at 6.

Test Plan:
- Reset, then request loop_start=0x100, sbb=0x180, ack always 1 → writes to slot 0: (0,0x180), (1,0x100), (2,1); done_valid at cycle 5 with done_rca=0, done_hit=0.
- Repeat 0x100 → done_hit=1, done_rca=0 at cycle 2; att_wr_valid never asserts.
- Fill 4 slots with 0x100/0x200/0x300/0x400, then install 0x500 → first write is (slot 0, VALID, 0), then the 3 field writes to slot 0; a later 0x600 evicts slot 1.
- Ack delayed 3 cycles on every write → att_wr_valid, address, field and value stay stable each wait; the sequence order is unchanged.
- flush pulse during WR_LSA → the install finishes with a done pulse; then 4 (VALID, 0) writes to slots 0..3; req_ready=0 throughout; a later install of 0x100 uses slot 0 with done_hit=0.
- rst asserted during a delayed WR_SBB → the next cycle shows att_wr_valid=0, busy=0, req_ready=1; the next install uses slot 0.
